// File: rtl/bin_serializer.sv
// bin_serializer: replays a parallel frame of BINS words as a serial stream.
// Define BIN_SER_DBUF_EN for a ping-pong buffer accepting during SEND.
module bin_serializer #(
  parameter int N          = 16,
  parameter int BINS       = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BINS*N-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [CNT_W-1:0]  frame_count
);

`ifdef BIN_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  localparam int IW    = (BINS > 1) ? $clog2(BINS) : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [IW-1:0] LAST_BIN = IW'(BINS - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GLAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [GW-1:0]          gcnt_q;
  logic [1:0][BINS*N-1:0] buf_q;
  logic [1:0]             full_q;
  logic [1:0]             full_d;
  logic                   wr_ptr_q;
  logic                   wr_ptr_d;
  logic                   rd_ptr_q;
  logic                   rd_ptr_d;
  logic                   in_ready_q;
  logic                   in_ready_d;
  logic [N-1:0]           out_data_q;
  logic                   out_valid_q;
  logic                   out_sof_q;
  logic                   out_eof_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   accept;
  logic                   last_hs;
  logic                   next_full;

  function automatic logic [N-1:0] bin_word(
    input logic [BINS*N-1:0] f,
    input logic [IW-1:0]     i
  );
    return f[int'(i)*N +: N];
  endfunction

  // Buffer occupancy: fill on accept, free on the last-sample handshake.
  always_comb begin
    accept   = in_valid && in_ready_q;
    last_hs  = (state_q == S_SEND) && out_valid_q
             && out_ready && (idx_q == LAST_BIN);
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (last_hs) begin
      full_d[rd_ptr_q] = 1'b0;
      if (DBUF) rd_ptr_d = ~rd_ptr_q;
    end
    if (accept) begin
      full_d[wr_ptr_q] = 1'b1;
      if (DBUF) wr_ptr_d = ~wr_ptr_q;
    end
    in_ready_d = DBUF ? !(&full_d) : !full_d[0];
    next_full  = full_q[~rd_ptr_q];
  end

  // Frame buffer control state and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Frame buffer data; contents are meaningless while marked empty.
  always_ff @(posedge clk) begin
    if (!reset && accept) buf_q[wr_ptr_q] <= in_data;
  end

  // Serializer FSM with registered sample outputs and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (full_q[rd_ptr_q]) begin
            state_q <= S_SEND;
            idx_q   <= '0;
          end
        end
        S_SEND: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bin_word(buf_q[rd_ptr_q], idx_q);
            out_sof_q   <= (idx_q == '0);
            out_eof_q   <= (idx_q == LAST_BIN);
          end else if (out_ready) begin
            if (idx_q != LAST_BIN) begin
              idx_q      <= idx_q + 1'b1;
              out_data_q <= bin_word(buf_q[rd_ptr_q],
                                     idx_q + 1'b1);
              out_sof_q  <= 1'b0;
              out_eof_q  <= ((idx_q + 1'b1) == LAST_BIN);
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              idx_q  <= '0;
              gcnt_q <= '0;
              if (DBUF && GAP_CYCLES == 0 && next_full) begin
                out_data_q <= bin_word(buf_q[~rd_ptr_q], '0);
                out_sof_q  <= 1'b1;
                out_eof_q  <= 1'b0;
              end else begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
                out_eof_q   <= 1'b0;
                state_q     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gcnt_q == LAST_GAP) begin
            gcnt_q  <= '0;
            state_q <= (DBUF && full_q[rd_ptr_q]) ? S_SEND : S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_bin_serializer.sv
// tb_bin_serializer: directed and randomized checks of bin_serializer
// against a frame-queue reference model.
module tb_bin_serializer;

  localparam int N     = 16;
  localparam int BINS  = 4;
  localparam int CNT_W = 4;
  localparam int FW    = BINS * N;
`ifdef BIN_SER_DBUF_EN
  localparam int GAP = 0;
  localparam int CAP = 2;
`else
  localparam int GAP = 2;
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [FW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic [CNT_W-1:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [FW-1:0] exp_q[$];
  int pos = 0;
  int exp_frames = 0;
  int hs = 0;
  bit mon_en = 1'b0;

  bin_serializer #(
    .N(N),
    .BINS(BINS),
    .GAP_CYCLES(GAP),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof(out_sof),
    .out_eof(out_eof),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] rnd_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int b = 0; b < BINS; b++) f[b*N +: N] = N'($urandom);
    return f;
  endfunction

  // Reference: queue of accepted frames, emitted whole and in order.
  task automatic monitor();
    logic [FW-1:0] f;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("in_ready", in_ready, exp_q.size() < CAP);
        check("frame_count", frame_count,
              exp_frames % (1 << CNT_W));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", out_valid, 0);
          end else begin
            f = exp_q[0];
            check("out_data", out_data, f[pos*N +: N]);
            check("out_sof", out_sof, pos == 0);
            check("out_eof", out_eof, pos == BINS - 1);
          end
        end
      end
      if (reset) begin
        exp_q.delete();
        pos = 0;
        exp_frames = 0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          hs++;
          pos++;
          if (pos == BINS) begin
            void'(exp_q.pop_front());
            pos = 0;
            exp_frames++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [FW-1:0] d);
    int k = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("accept_wait", k < 200, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain", k < 500, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] f1;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    logic [FW-1:0] g;
    logic [15:0]   sofm;
    logic [15:0]   eofm;
    int first, rdy, k, k2, held, gap, run, hs0;
    bit done;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    f1 = 64'h4444_3333_2222_1111;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_count", frame_count, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Latency and in_ready release
    send(f1);
    first = -1;
    rdy = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && first < 0) first = c;
      if (in_ready && rdy < 0) rdy = c;
    end
    check("latency", first, 2);
`ifndef BIN_SER_DBUF_EN
    check("ready_return", rdy, 6);
`else
    check("ready_dbuf", rdy, 0);
`endif
    wait_drain();
    check("count_one", frame_count, 1);

    // Backpressure on bin 1
    send(f1);
    hs0 = hs;
    k = 0;
    while (!(out_valid && out_data == 16'h2222) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_reach", k < 50, 1);
    held = 0;
    fork
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (out_valid && out_data == 16'h2222) held++;
        end
      end
    join
    wait_drain();
    check("bp_held", held, 4);
    check("bp_samples", hs - hs0, 4);

    // Two frames offered back to back
    fa = rnd_frame();
    fb = rnd_frame();
    gap = 0;
    run = 0;
    sofm = '0;
    eofm = '0;
    fork
      begin
        send(fa);
        send(fb);
      end
      begin
`ifndef BIN_SER_DBUF_EN
        k2 = 0;
        while (!(out_valid && out_eof && out_ready) && k2 < 50) begin
          @(negedge clk);
          k2++;
        end
        check("eof_seen", k2 < 50, 1);
        @(negedge clk);
        while (!out_valid && gap < 20) begin
          gap++;
          @(negedge clk);
        end
        check("interframe_gap", gap, 4);
        check("sof_after_gap", out_sof, 1);
`else
        k2 = 0;
        while (!out_valid && k2 < 50) begin
          @(negedge clk);
          k2++;
        end
        while (out_valid && run < 16) begin
          sofm[run] = out_sof;
          eofm[run] = out_eof;
          run++;
          @(negedge clk);
        end
        check("dbuf_run", run, 8);
        check("dbuf_sof", sofm, 16'h0011);
        check("dbuf_eof", eofm, 16'h0088);
`endif
      end
    join
    wait_drain();

    // Reset right after the bin-1 handshake
    send(f1);
    k = 0;
    while (!(out_valid && out_data == 16'h2222) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_reach", k < 50, 1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_count", frame_count, 0);
    @(posedge clk);
    #1;
    g = rnd_frame();
    send(g);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("post_rst_sof", out_sof, 1);
    check("post_rst_bin0", out_data, g[N-1:0]);
    wait_drain();

    // Counter wrap
    pulse_reset();
    for (int i = 0; i < 15; i++) send(rnd_frame());
    wait_drain();
    check("count_15", frame_count, 15);
    send(rnd_frame());
    wait_drain();
    check("count_wrap", frame_count, 0);

    // Randomized traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send(rnd_frame());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_count", frame_count, 46 % 16);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
